// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the 7-segment scan receiver.
// Segment bit positions, lit-pattern table and FSM state encoding.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Entry i is the g..a lit pattern that displays hex value i.
    localparam logic [15:0][6:0] LIT_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        WRAP    = 2'd2
    } state_e;

endpackage

// File: rtl/seven_seg_decode.sv
// Lit-pattern to hex nibble decoder for one digit (dp excluded).
// Shared with the display-side self-check logic.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] lit,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       invalid
);

    always_comb begin
        nibble  = 4'd0;
        blank   = (lit == 7'h00);
        invalid = (lit != 7'h00);
        for (int i = 0; i < 16; i++) begin
            if (lit == LIT_TABLE[i]) begin
                nibble  = 4'(i);
                invalid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_rx.sv
// Receiver for a multiplexed 7-segment scan bus: rebuilds the 8-digit
// frame in shadow registers and publishes it atomically on wrap to digit 0.
module seven_seg_scan_rx
    import seven_seg_pkg::*;
#(
    parameter int SETTLE     = 4,
    parameter int TIMEOUT    = 1048576,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  scan_in,
    input  logic [7:0]  seg_in,
    output logic [31:0] digits_out,
    output logic [7:0]  blank_out,
    output logic [7:0]  invalid_out,
    output logic [7:0]  dp_out,
    output logic        frame_valid,
    output logic        seq_err,
    output logic        stall
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]  scan_s1_q, scan_s1_d;
    logic [2:0]  scan_s2_q, scan_s2_d;
    logic [7:0]  seg_s1_q, seg_s1_d;
    logic [7:0]  seg_s2_q, seg_s2_d;

    logic [CW-1:0] settle_q, settle_d;
    logic          taken_q, taken_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    state_e      state_q, state_d;
    logic [2:0]  exp_code_q, exp_code_d;

    logic [NUM_DIGITS-1:0][3:0] sh_nib_q, sh_nib_d;
    logic [NUM_DIGITS-1:0]      sh_blank_q, sh_blank_d;
    logic [NUM_DIGITS-1:0]      sh_inv_q, sh_inv_d;
    logic [NUM_DIGITS-1:0]      sh_dp_q, sh_dp_d;

    logic [31:0] digits_q, digits_d;
    logic [7:0]  blank_q, blank_d;
    logic [7:0]  inv_q, inv_d;
    logic [7:0]  dp_q, dp_d;
    logic        fv_q, fv_d;
    logic        seq_err_q, seq_err_d;

    logic        scan_chg;
    logic        fire;
    logic        stalled;
    logic [7:0]  seg_lit;
    logic [6:0]  lit;
    logic        dp_lit;
    logic [3:0]  dec_nib;
    logic        dec_blank;
    logic        dec_inv;
    logic        store;
    logic        commit;

    always_comb begin
        scan_s1_d = scan_in;
        scan_s2_d = scan_s1_q;
        seg_s1_d  = seg_in;
        seg_s2_d  = seg_s1_q;
    end

    // s1 differing from s2 means the synchronized code changes this edge.
    assign scan_chg = (scan_s1_q != scan_s2_q);
    assign fire     = (settle_q == CW'(SETTLE)) && !taken_q;
    assign stalled  = (to_cnt_q == TW'(TIMEOUT));

    assign seg_lit = ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;
    assign lit     = {seg_lit[SEG_G], seg_lit[SEG_F], seg_lit[SEG_E],
                      seg_lit[SEG_D], seg_lit[SEG_C], seg_lit[SEG_B],
                      seg_lit[SEG_A]};
    assign dp_lit  = seg_lit[SEG_DP];

    seven_seg_decode u_decode (
        .lit     (lit),
        .nibble  (dec_nib),
        .blank   (dec_blank),
        .invalid (dec_inv)
    );

    always_comb begin
        settle_d = settle_q;
        taken_d  = taken_q;
        to_cnt_d = to_cnt_q;
        if (scan_chg) begin
            settle_d = '0;
            taken_d  = 1'b0;
            to_cnt_d = '0;
        end else begin
            if (settle_q != CW'(SETTLE)) begin
                settle_d = settle_q + 1'b1;
            end
            if (fire) begin
                taken_d = 1'b1;
            end
            if (!stalled) begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        exp_code_d = exp_code_q;
        seq_err_d  = seq_err_q;
        store      = 1'b0;
        commit     = 1'b0;
        if (stalled && scan_chg) begin
            state_d = HUNT;
        end else if (fire) begin
            unique case (state_q)
                HUNT: begin
                    if (scan_s2_q == 3'd0) begin
                        store      = 1'b1;
                        state_d    = COLLECT;
                        exp_code_d = 3'd1;
                    end
                end
                COLLECT: begin
                    if (scan_s2_q == exp_code_q) begin
                        store = 1'b1;
                        if (exp_code_q == 3'd7) begin
                            state_d = WRAP;
                        end else begin
                            exp_code_d = exp_code_q + 3'd1;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        if (scan_s2_q == 3'd0) begin
                            store      = 1'b1;
                            exp_code_d = 3'd1;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                WRAP: begin
                    if (scan_s2_q == 3'd0) begin
                        commit     = 1'b1;
                        store      = 1'b1;
                        state_d    = COLLECT;
                        exp_code_d = 3'd1;
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Commit reads the old shadow while slot 0 of the new frame is written.
    always_comb begin
        sh_nib_d   = sh_nib_q;
        sh_blank_d = sh_blank_q;
        sh_inv_d   = sh_inv_q;
        sh_dp_d    = sh_dp_q;
        digits_d   = digits_q;
        blank_d    = blank_q;
        inv_d      = inv_q;
        dp_d       = dp_q;
        fv_d       = commit;
        if (store) begin
            sh_nib_d[scan_s2_q]   = dec_nib;
            sh_blank_d[scan_s2_q] = dec_blank;
            sh_inv_d[scan_s2_q]   = dec_inv;
            sh_dp_d[scan_s2_q]    = dp_lit;
        end
        if (commit) begin
            digits_d = sh_nib_q;
            blank_d  = sh_blank_q;
            inv_d    = sh_inv_q;
            dp_d     = sh_dp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_s1_q  <= '0;
            scan_s2_q  <= '0;
            seg_s1_q   <= '0;
            seg_s2_q   <= '0;
            settle_q   <= '0;
            taken_q    <= 1'b0;
            to_cnt_q   <= '0;
            state_q    <= HUNT;
            exp_code_q <= '0;
            sh_nib_q   <= '0;
            sh_blank_q <= '0;
            sh_inv_q   <= '0;
            sh_dp_q    <= '0;
            digits_q   <= '0;
            blank_q    <= 8'hFF;
            inv_q      <= '0;
            dp_q       <= '0;
            fv_q       <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            scan_s1_q  <= scan_s1_d;
            scan_s2_q  <= scan_s2_d;
            seg_s1_q   <= seg_s1_d;
            seg_s2_q   <= seg_s2_d;
            settle_q   <= settle_d;
            taken_q    <= taken_d;
            to_cnt_q   <= to_cnt_d;
            state_q    <= state_d;
            exp_code_q <= exp_code_d;
            sh_nib_q   <= sh_nib_d;
            sh_blank_q <= sh_blank_d;
            sh_inv_q   <= sh_inv_d;
            sh_dp_q    <= sh_dp_d;
            digits_q   <= digits_d;
            blank_q    <= blank_d;
            inv_q      <= inv_d;
            dp_q       <= dp_d;
            fv_q       <= fv_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign digits_out  = digits_q;
    assign blank_out   = blank_q;
    assign invalid_out = inv_q;
    assign dp_out      = dp_q;
    assign frame_valid = fv_q;
    assign seq_err     = seq_err_q;
    assign stall       = stalled;

endmodule

// File: tb/tb_seven_seg_scan_rx.sv
// Bench for seven_seg_scan_rx: frame vectors with a commit scoreboard,
// plus sequences for sequence errors, short dwell, stall and mid-frame reset.
module tb_seven_seg_scan_rx;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  scan_in;
    logic [7:0]  seg_in;
    logic [31:0] digits_out;
    logic [7:0]  blank_out;
    logic [7:0]  invalid_out;
    logic [7:0]  dp_out;
    logic        frame_valid;
    logic        seq_err;
    logic        stall;

    seven_seg_scan_rx #(
        .SETTLE     (SETTLE),
        .TIMEOUT    (TIMEOUT),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_in     (scan_in),
        .seg_in      (seg_in),
        .digits_out  (digits_out),
        .blank_out   (blank_out),
        .invalid_out (invalid_out),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .seq_err     (seq_err),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [7:0][7:0] seg;
        logic [31:0]     digits;
        logic [7:0]      blank;
        logic [7:0]      inv;
        logic [7:0]      dp;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] digits;
        logic [7:0]  blank;
        logic [7:0]  inv;
        logic [7:0]  dp;
        int          cyc;
    } sb_t;

    vec_t vecs [4];
    sb_t  sb_q [$];
    sb_t  got;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Scoreboard: every frame_valid must match the oldest pending frame.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame: got frame_valid=1 digits=%h required no commit",
                         digits_out);
            end else begin
                got = sb_q.pop_front();
                chk({got.name, "_digits"}, 64'(digits_out), 64'(got.digits));
                chk({got.name, "_blank"}, 64'(blank_out), 64'(got.blank));
                chk({got.name, "_invalid"}, 64'(invalid_out), 64'(got.inv));
                chk({got.name, "_dp"}, 64'(dp_out), 64'(got.dp));
                chk({got.name, "_latency"}, 64'(cyc - got.cyc), 64'(SETTLE + 3));
            end
        end
    end

    task automatic drive(input int code, input logic [7:0] seg, input int dwell);
        scan_in = 3'(code);
        seg_in  = seg;
        repeat (dwell) @(negedge clk);
    endtask

    task automatic park();
        drive(7, 8'hFF, 4);
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk({name, "_rst_digits"}, 64'(digits_out), 64'h0);
        chk({name, "_rst_flags"},
            64'({blank_out, invalid_out, dp_out, frame_valid, seq_err, stall}),
            64'({8'hFF, 8'h00, 8'h00, 3'b000}));
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_exp(input vec_t v);
        sb_t s;
        s.name   = v.name;
        s.digits = v.digits;
        s.blank  = v.blank;
        s.inv    = v.inv;
        s.dp     = v.dp;
        s.cyc    = cyc;
        sb_q.push_back(s);
    endtask

    task automatic send_frame(input vec_t v, input bit push);
        for (int k = 0; k < 8; k++) drive(k, v.seg[k], 20);
        if (push) push_exp(v);
        drive(0, v.seg[0], 20);
    endtask

    task automatic chk_sb_empty(input string name);
        chk({name, "_pending"}, 64'(sb_q.size()), 64'h0);
    endtask

    initial begin
        vecs[0].name   = "digits_0_7";
        vecs[0].seg    = {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
        vecs[0].digits = 32'h76543210;
        vecs[0].blank  = 8'h00;
        vecs[0].inv    = 8'h00;
        vecs[0].dp     = 8'h00;

        vecs[1].name   = "blank_dp";
        vecs[1].seg    = {8'hF8, 8'h82, 8'h12, 8'h99, 8'hFF, 8'hA4, 8'hF9, 8'hC0};
        vecs[1].digits = 32'h76540210;
        vecs[1].blank  = 8'h08;
        vecs[1].inv    = 8'h00;
        vecs[1].dp     = 8'h20;

        vecs[2].name   = "hex_8_f";
        vecs[2].seg    = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
        vecs[2].digits = 32'hFEDCBA98;
        vecs[2].blank  = 8'h00;
        vecs[2].inv    = 8'h00;
        vecs[2].dp     = 8'h00;

        vecs[3].name   = "invalid_mix";
        vecs[3].seg    = {8'hF8, 8'h00, 8'h92, 8'h99, 8'hB0, 8'hB6, 8'hF9, 8'hFF};
        vecs[3].digits = 32'h78543010;
        vecs[3].blank  = 8'h01;
        vecs[3].inv    = 8'h04;
        vecs[3].dp     = 8'h40;

        reset   = 1'b1;
        scan_in = 3'd7;
        seg_in  = 8'hFF;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            park();
            do_reset(vecs[i].name);
            send_frame(vecs[i], 1'b1);
            chk_sb_empty(vecs[i].name);
            chk({vecs[i].name, "_seq_err"}, 64'(seq_err), 64'h0);
        end

        // Out-of-order code 4 after 2; a clean frame still commits afterwards.
        park();
        do_reset("seq");
        drive(0, vecs[0].seg[0], 20);
        drive(1, vecs[0].seg[1], 20);
        drive(2, vecs[0].seg[2], 20);
        drive(4, vecs[0].seg[4], 20);
        chk("seq_err_set", 64'(seq_err), 64'h1);
        send_frame(vecs[0], 1'b1);
        chk_sb_empty("seq");
        chk("seq_err_sticky", 64'(seq_err), 64'h1);

        // Code 2 dwells too briefly to be sampled.
        park();
        do_reset("short");
        drive(0, vecs[0].seg[0], 20);
        drive(1, vecs[0].seg[1], 20);
        drive(2, vecs[0].seg[2], 3);
        for (int k = 3; k < 8; k++) drive(k, vecs[0].seg[k], 20);
        drive(0, vecs[0].seg[0], 20);
        chk("short_seq_err", 64'(seq_err), 64'h1);
        chk("short_no_commit", 64'(digits_out), 64'h0);
        chk_sb_empty("short");

        // Scan code held on 4 long enough to stall.
        park();
        do_reset("stall");
        for (int k = 0; k < 4; k++) drive(k, vecs[0].seg[k], 20);
        drive(4, vecs[0].seg[4], 40);
        chk("stall_early", 64'(stall), 64'h0);
        repeat (60) @(negedge clk);
        chk("stall_high", 64'(stall), 64'h1);
        drive(5, vecs[0].seg[5], 4);
        chk("stall_cleared", 64'(stall), 64'h0);
        repeat (16) @(negedge clk);
        drive(6, vecs[0].seg[6], 20);
        drive(7, vecs[0].seg[7], 20);
        send_frame(vecs[0], 1'b1);
        chk_sb_empty("stall");

        // Reset after digits 0..4 of a second frame.
        park();
        do_reset("midrst");
        send_frame(vecs[0], 1'b1);
        for (int k = 1; k < 5; k++) drive(k, vecs[1].seg[k], 20);
        do_reset("midrst_hit");
        for (int k = 5; k < 8; k++) drive(k, vecs[1].seg[k], 20);
        send_frame(vecs[1], 1'b1);
        chk_sb_empty("midrst");

        repeat (10) @(negedge clk);
        chk_sb_empty("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
